// File: rtl/rf_wb_port_arbiter.sv
// Register-file write-port arbiter: pipeline writeback has priority, MDU results queue in a FIFO.
// Latency: pipe path 0 cycles (combinational); MDU path >= 1 cycle through the result FIFO.
// Backpressure: mdu_ready drops when the FIFO is full; stall_req asks for a bubble when the head starves.
module rf_wb_port_arbiter #(
    parameter int XLEN     = 32,
    parameter int DEPTH    = 4,
    parameter int MAX_WAIT = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     pipe_we,
    input  logic [4:0]               pipe_rd,
    input  logic [XLEN-1:0]          pipe_wd,
    input  logic                     mdu_valid,
    input  logic [4:0]               mdu_rd,
    input  logic [XLEN-1:0]          mdu_wd,
    output logic                     mdu_ready,
    output logic                     rf_we,
    output logic [4:0]               rf_rd,
    output logic [XLEN-1:0]          rf_wd,
    output logic                     stall_req,
    output logic [31:0]              pending_mask,
    output logic [$clog2(DEPTH):0]   fifo_count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int AW = $clog2(MAX_WAIT) + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [AW-1:0] AGE_MAX = AW'(MAX_WAIT - 1);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DRAIN} state_t;

    // FIFO storage; unoccupied slots always hold valid=0 so the mask can scan every slot
    logic [4:0]      ent_rd [DEPTH];
    logic [XLEN-1:0] ent_wd [DEPTH];
    logic [DEPTH-1:0] ent_vld;
    logic [DEPTH-1:0] vld_nxt;
    logic [PW-1:0]   rd_ptr;
    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   rd_ptr_nxt;
    logic [CW-1:0]   count;
    logic [CW-1:0]   count_nxt;

    logic            pipe_wr;
    logic            push;
    logic            pop;
    logic            head_vld;
    logic            nxt_head_vld;

    state_t          state;
    logic [AW-1:0]   age;

    // x0 writes are architecturally dropped, so they leave the port free for the FIFO head
    assign pipe_wr    = pipe_we && (pipe_rd != 5'd0);
    assign mdu_ready  = !rst && (count < DEPTH_C);
    assign push       = mdu_valid && mdu_ready;
    assign pop        = !rst && !pipe_wr && (count != '0);
    assign head_vld   = (count != '0) && ent_vld[rd_ptr];
    assign fifo_count = count;

    // Write port: pipe wins, otherwise the head (squashed heads are popped silently)
    always_comb begin
        rf_we = 1'b0;
        rf_rd = 5'd0;
        rf_wd = '0;
        if (!rst) begin
            if (pipe_wr) begin
                rf_we = 1'b1;
                rf_rd = pipe_rd;
                rf_wd = pipe_wd;
            end else if (count != '0) begin
                rf_we = ent_vld[rd_ptr];
                rf_rd = ent_rd[rd_ptr];
                rf_wd = ent_wd[rd_ptr];
            end
        end
    end

    // Next-cycle valid bits: pop clears head, pipe write squashes older same-rd entries, push sets new slot last
    always_comb begin
        vld_nxt = ent_vld;
        if (pop) begin
            vld_nxt[rd_ptr] = 1'b0;
        end
        if (pipe_wr) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (ent_rd[i] == pipe_rd) begin
                    vld_nxt[i] = 1'b0;
                end
            end
        end
        if (push) begin
            vld_nxt[wr_ptr] = (mdu_rd != 5'd0);
        end
    end

    assign rd_ptr_nxt   = pop ? rd_ptr + PW'(1) : rd_ptr;
    assign count_nxt    = count + CW'(push) - CW'(pop);
    assign nxt_head_vld = (count_nxt != '0) && vld_nxt[rd_ptr_nxt];

    // Pending-write view of queued valid entries
    always_comb begin
        pending_mask = 32'd0;
        for (int i = 0; i < DEPTH; i++) begin
            if (ent_vld[i]) begin
                pending_mask[ent_rd[i]] = 1'b1;
            end
        end
    end

    // FIFO pointers, occupancy and entry payloads
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            count   <= '0;
            ent_vld <= '0;
        end else begin
            ent_vld <= vld_nxt;
            count   <= count_nxt;
            rd_ptr  <= rd_ptr_nxt;
            if (push) begin
                ent_rd[wr_ptr] <= mdu_rd;
                ent_wd[wr_ptr] <= mdu_wd;
                wr_ptr         <= wr_ptr + PW'(1);
            end
        end
    end

    // Starvation FSM: counts cycles a valid head is blocked, requests a bubble once it has waited MAX_WAIT
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            age       <= '0;
            stall_req <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    age       <= '0;
                    stall_req <= 1'b0;
                    if (nxt_head_vld) begin
                        state <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (pop || !head_vld || !nxt_head_vld && !head_vld) begin
                        age       <= '0;
                        state     <= nxt_head_vld ? S_WAIT : S_IDLE;
                        stall_req <= 1'b0;
                    end else if (age == AGE_MAX) begin
                        state     <= S_DRAIN;
                        stall_req <= 1'b1;
                    end else begin
                        age <= age + AW'(1);
                    end
                end
                S_DRAIN: begin
                    if (pop || !head_vld || !vld_nxt[rd_ptr]) begin
                        age       <= '0;
                        state     <= nxt_head_vld ? S_WAIT : S_IDLE;
                        stall_req <= 1'b0;
                    end
                end
                default: begin
                    state     <= S_IDLE;
                    age       <= '0;
                    stall_req <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rf_wb_port_arbiter.sv
module tb_rf_wb_port_arbiter;

    logic        clk;
    logic        rst;
    logic        pipe_we;
    logic [4:0]  pipe_rd;
    logic [31:0] pipe_wd;
    logic        mdu_valid;
    logic [4:0]  mdu_rd;
    logic [31:0] mdu_wd;
    logic        mdu_ready;
    logic        rf_we;
    logic [4:0]  rf_rd;
    logic [31:0] rf_wd;
    logic        stall_req;
    logic [31:0] pending_mask;
    logic [2:0]  fifo_count;

    int checks;
    int failures;

    rf_wb_port_arbiter #(.XLEN(32), .DEPTH(4), .MAX_WAIT(8)) dut (
        .clk          (clk),
        .rst          (rst),
        .pipe_we      (pipe_we),
        .pipe_rd      (pipe_rd),
        .pipe_wd      (pipe_wd),
        .mdu_valid    (mdu_valid),
        .mdu_rd       (mdu_rd),
        .mdu_wd       (mdu_wd),
        .mdu_ready    (mdu_ready),
        .rf_we        (rf_we),
        .rf_rd        (rf_rd),
        .rf_wd        (rf_wd),
        .stall_req    (stall_req),
        .pending_mask (pending_mask),
        .fifo_count   (fifo_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    // Advance to 1 time unit after the next rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; pipe_we = 1'b1; pipe_rd = 5'd5; pipe_wd = 32'h1;
        mdu_valid = 1'b1; mdu_rd = 5'd4; mdu_wd = 32'h2;
        #1;
        checks++; if (mdu_ready !== 1'b0) begin failures++; $display("FAIL rst_mdu_ready got=%b exp=0", mdu_ready); end
        checks++; if (rf_we !== 1'b0) begin failures++; $display("FAIL rst_rf_we got=%b exp=0", rf_we); end
        checks++; if (rf_rd !== 5'd0 || rf_wd !== 32'd0) begin failures++; $display("FAIL rst_rf_addr_data got=%0d/%h exp=0/0", rf_rd, rf_wd); end
        tick(); tick();
        checks++; if (fifo_count !== 3'd0) begin failures++; $display("FAIL rst_count got=%0d exp=0", fifo_count); end
        checks++; if (pending_mask !== 32'd0) begin failures++; $display("FAIL rst_mask got=%h exp=0", pending_mask); end
        checks++; if (stall_req !== 1'b0) begin failures++; $display("FAIL rst_stall got=%b exp=0", stall_req); end
        rst = 1'b0; pipe_we = 1'b0; mdu_valid = 1'b0;
        #1;
        checks++; if (mdu_ready !== 1'b1) begin failures++; $display("FAIL post_rst_ready got=%b exp=1", mdu_ready); end
        checks++; if (rf_we !== 1'b0) begin failures++; $display("FAIL post_rst_rf_we got=%b exp=0", rf_we); end
        tick();
    endtask

    task automatic test_pipe_only();
        pipe_we = 1'b1; pipe_rd = 5'd5; pipe_wd = 32'hDEADBEEF;
        #1;
        checks++; if (rf_we !== 1'b1 || rf_rd !== 5'd5 || rf_wd !== 32'hDEADBEEF) begin
            failures++; $display("FAIL pipe_only got=%b/%0d/%h exp=1/5/deadbeef", rf_we, rf_rd, rf_wd); end
        tick();
        pipe_we = 1'b0;
    endtask

    task automatic test_mdu_idle();
        mdu_valid = 1'b1; mdu_rd = 5'd7; mdu_wd = 32'h11;
        #1;
        checks++; if (rf_we !== 1'b0) begin failures++; $display("FAIL mdu_same_cycle_we got=%b exp=0", rf_we); end
        tick();
        mdu_valid = 1'b0;
        #1;
        checks++; if (fifo_count !== 3'd1) begin failures++; $display("FAIL mdu_count1 got=%0d exp=1", fifo_count); end
        checks++; if (pending_mask !== 32'h80) begin failures++; $display("FAIL mdu_mask7 got=%h exp=80", pending_mask); end
        checks++; if (rf_we !== 1'b1 || rf_rd !== 5'd7 || rf_wd !== 32'h11) begin
            failures++; $display("FAIL mdu_write got=%b/%0d/%h exp=1/7/11", rf_we, rf_rd, rf_wd); end
        tick();
        checks++; if (fifo_count !== 3'd0 || pending_mask !== 32'd0) begin
            failures++; $display("FAIL mdu_drained got=%0d/%h exp=0/0", fifo_count, pending_mask); end
    endtask

    task automatic test_full_stall();
        pipe_we = 1'b1; pipe_rd = 5'd1; pipe_wd = 32'h77;
        for (int i = 0; i < 4; i++) begin
            mdu_valid = 1'b1; mdu_rd = 5'(10 + i); mdu_wd = 32'h100 + 32'(i);
            #1;
            checks++; if (mdu_ready !== 1'b1) begin failures++; $display("FAIL full_push_ready%0d got=%b exp=1", i, mdu_ready); end
            tick();
        end
        mdu_rd = 5'd20; mdu_wd = 32'h999;
        #1;
        checks++; if (mdu_ready !== 1'b0) begin failures++; $display("FAIL full_fifth_ready got=%b exp=0", mdu_ready); end
        tick();
        mdu_valid = 1'b0;
        #1;
        checks++; if (fifo_count !== 3'd4) begin failures++; $display("FAIL full_count got=%0d exp=4", fifo_count); end
        checks++; if (pending_mask !== 32'h3C00) begin failures++; $display("FAIL full_mask got=%h exp=3c00", pending_mask); end
        for (int c = 5; c <= 8; c++) begin
            checks++; if (stall_req !== 1'b0) begin failures++; $display("FAIL early_stall_c%0d got=%b exp=0", c, stall_req); end
            tick();
        end
        checks++; if (stall_req !== 1'b1) begin failures++; $display("FAIL stall_after_wait got=%b exp=1", stall_req); end
        pipe_we = 1'b0;
        #1;
        checks++; if (rf_we !== 1'b1 || rf_rd !== 5'd10 || rf_wd !== 32'h100) begin
            failures++; $display("FAIL drain_head got=%b/%0d/%h exp=1/10/100", rf_we, rf_rd, rf_wd); end
        tick();
        checks++; if (stall_req !== 1'b0) begin failures++; $display("FAIL stall_fall got=%b exp=0", stall_req); end
        checks++; if (fifo_count !== 3'd3) begin failures++; $display("FAIL drain_count got=%0d exp=3", fifo_count); end
        for (int i = 1; i < 4; i++) begin
            checks++; if (rf_we !== 1'b1 || rf_rd !== 5'(10 + i) || rf_wd !== 32'h100 + 32'(i)) begin
                failures++; $display("FAIL drain_entry%0d got=%b/%0d/%h", i, rf_we, rf_rd, rf_wd); end
            tick();
        end
        checks++; if (fifo_count !== 3'd0 || stall_req !== 1'b0) begin
            failures++; $display("FAIL drain_empty got=%0d/%b exp=0/0", fifo_count, stall_req); end
    endtask

    task automatic test_squash();
        mdu_valid = 1'b1; mdu_rd = 5'd3; mdu_wd = 32'hA;
        tick();
        mdu_valid = 1'b0; pipe_we = 1'b1; pipe_rd = 5'd3; pipe_wd = 32'hB;
        #1;
        checks++; if (rf_we !== 1'b1 || rf_rd !== 5'd3 || rf_wd !== 32'hB) begin
            failures++; $display("FAIL squash_pipe got=%b/%0d/%h exp=1/3/b", rf_we, rf_rd, rf_wd); end
        tick();
        pipe_we = 1'b0;
        #1;
        checks++; if (fifo_count !== 3'd1 || pending_mask !== 32'd0) begin
            failures++; $display("FAIL squash_state got=%0d/%h exp=1/0", fifo_count, pending_mask); end
        checks++; if (rf_we !== 1'b0) begin failures++; $display("FAIL squash_pop_we got=%b exp=0", rf_we); end
        tick();
        checks++; if (fifo_count !== 3'd0) begin failures++; $display("FAIL squash_popped got=%0d exp=0", fifo_count); end
        // Same-cycle push is younger than the pipe write and must survive
        mdu_valid = 1'b1; mdu_rd = 5'd3; mdu_wd = 32'hA;
        tick();
        mdu_wd = 32'hC; pipe_we = 1'b1; pipe_rd = 5'd3; pipe_wd = 32'hB;
        tick();
        mdu_valid = 1'b0; pipe_we = 1'b0;
        #1;
        checks++; if (fifo_count !== 3'd2 || pending_mask !== 32'h8) begin
            failures++; $display("FAIL young_state got=%0d/%h exp=2/8", fifo_count, pending_mask); end
        checks++; if (rf_we !== 1'b0) begin failures++; $display("FAIL young_old_we got=%b exp=0", rf_we); end
        tick();
        checks++; if (rf_we !== 1'b1 || rf_rd !== 5'd3 || rf_wd !== 32'hC) begin
            failures++; $display("FAIL young_write got=%b/%0d/%h exp=1/3/c", rf_we, rf_rd, rf_wd); end
        tick();
        checks++; if (fifo_count !== 3'd0 || pending_mask !== 32'd0) begin
            failures++; $display("FAIL young_empty got=%0d/%h exp=0/0", fifo_count, pending_mask); end
    endtask

    task automatic test_x0();
        mdu_valid = 1'b1; mdu_rd = 5'd9; mdu_wd = 32'h99;
        tick();
        mdu_valid = 1'b0; pipe_we = 1'b1; pipe_rd = 5'd0; pipe_wd = 32'h55;
        #1;
        checks++; if (rf_we !== 1'b1 || rf_rd !== 5'd9 || rf_wd !== 32'h99) begin
            failures++; $display("FAIL x0_pipe_yields got=%b/%0d/%h exp=1/9/99", rf_we, rf_rd, rf_wd); end
        tick();
        pipe_we = 1'b0;
        checks++; if (fifo_count !== 3'd0) begin failures++; $display("FAIL x0_pop_count got=%0d exp=0", fifo_count); end
        mdu_valid = 1'b1; mdu_rd = 5'd0; mdu_wd = 32'h66;
        #1;
        checks++; if (mdu_ready !== 1'b1) begin failures++; $display("FAIL x0_mdu_ready got=%b exp=1", mdu_ready); end
        tick();
        mdu_valid = 1'b0;
        #1;
        checks++; if (fifo_count !== 3'd1 || pending_mask !== 32'd0 || rf_we !== 1'b0) begin
            failures++; $display("FAIL x0_mdu_entry got=%0d/%h/%b exp=1/0/0", fifo_count, pending_mask, rf_we); end
        tick();
        checks++; if (fifo_count !== 3'd0) begin failures++; $display("FAIL x0_mdu_popped got=%0d exp=0", fifo_count); end
    endtask

    task automatic test_reset_drain();
        int n;
        pipe_we = 1'b1; pipe_rd = 5'd1; pipe_wd = 32'h5;
        for (int i = 0; i < 3; i++) begin
            mdu_valid = 1'b1; mdu_rd = 5'(20 + i); mdu_wd = 32'(i);
            tick();
        end
        mdu_valid = 1'b0;
        n = 0;
        while (stall_req !== 1'b1 && n < 30) begin
            tick();
            n++;
        end
        checks++; if (stall_req !== 1'b1) begin failures++; $display("FAIL drain_reached got=%b exp=1", stall_req); end
        checks++; if (fifo_count !== 3'd3) begin failures++; $display("FAIL drain_entries got=%0d exp=3", fifo_count); end
        rst = 1'b1;
        #1;
        checks++; if (mdu_ready !== 1'b0 || rf_we !== 1'b0) begin
            failures++; $display("FAIL midrst_outputs got=%b/%b exp=0/0", mdu_ready, rf_we); end
        tick();
        rst = 1'b0; pipe_we = 1'b0;
        #1;
        checks++; if (fifo_count !== 3'd0 || pending_mask !== 32'd0) begin
            failures++; $display("FAIL midrst_cleared got=%0d/%h exp=0/0", fifo_count, pending_mask); end
        checks++; if (stall_req !== 1'b0 || mdu_ready !== 1'b1) begin
            failures++; $display("FAIL midrst_ctrl got=%b/%b exp=0/1", stall_req, mdu_ready); end
        tick();
    endtask

    initial begin
        checks = 0; failures = 0;
        rst = 1'b1; pipe_we = 1'b0; pipe_rd = 5'd0; pipe_wd = 32'd0;
        mdu_valid = 1'b0; mdu_rd = 5'd0; mdu_wd = 32'd0;
        test_reset();
        test_pipe_only();
        test_mdu_idle();
        test_full_stall();
        test_squash();
        test_x0();
        test_reset_drain();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
